muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller for the pipelined CPU's EX stage. It sequences a shared 32-bit add/subtract/shift datapath over WIDTH cycles and owns the HI/LO result registers. It stalls the pipeline when a new mult/div or an mfhi/mflo read arrives while an operation is still in progress.

---
 rtl/muldiv_sequencer_if.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake bundle for the iterative multiply/divide unit.
// MULDIV_HILO_WRITE_EN adds the mthi/mtlo write port.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_read;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_HILO_WRITE_EN
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output start, op, rs_val, rt_val, hilo_read,
        output hi_wr, lo_wr, wr_data,
        input  busy, done, div_by_zero, stall, hi, lo
    );
    modport slave (
        input  start, op, rs_val, rt_val, hilo_read,
        input  hi_wr, lo_wr, wr_data,
        output busy, done, div_by_zero, stall, hi, lo
    );
`else
    modport master (
        output start, op, rs_val, rt_val, hilo_read,
        input  busy, done, div_by_zero, stall, hi, lo
    );
    modport slave (
        input  start, op, rs_val, rt_val, hilo_read,
        output busy, done, div_by_zero, stall, hi, lo
    );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO for the EX stage.
// Optional MULDIV_HILO_WRITE_EN enables mthi/mtlo writes when idle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   rs_r;
    logic [WIDTH-1:0]   rt_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               is_div;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   abs_rs;
    logic [WIDTH-1:0]   abs_rt;
    logic               dz_cond;
    logic               busy;
    logic               accept;
    logic [WIDTH:0]     sum;

    assign is_div  = op_r[1];
    assign rs_neg  = ~op_r[0] & rs_r[WIDTH-1];
    assign rt_neg  = ~op_r[0] & rt_r[WIDTH-1];
    assign abs_rs  = rs_neg ? -rs_r : rs_r;
    assign abs_rt  = rt_neg ? -rt_r : rt_r;
    assign dz_cond = is_div & (rt_r == '0);
    assign busy    = (state == PREP) | (state == RUN) | (state == FIX);
    assign accept  = bus.start & ~busy;

    // Shared adder: trial subtract of shifted remainder, or partial-product add.
    always_comb begin
        sum = '0;
        if (is_div) begin
            sum = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        end else begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = PREP;
            PREP:    state_nxt = dz_cond ? DONE : RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = bus.start ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_r  <= '0;
            rs_r  <= '0;
            rt_r  <= '0;
            opnd  <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            if (accept) begin
                op_r <= bus.op;
                rs_r <= bus.rs_val;
                rt_r <= bus.rt_val;
                dz   <= 1'b0;
            end
            if (state == PREP) begin
                cnt   <= '0;
                neg_q <= rs_neg ^ rt_neg;
                neg_r <= rs_neg;
                dz    <= dz_cond;
                opnd  <= is_div ? abs_rt : abs_rs;
                acc   <= {{WIDTH{1'b0}}, is_div ? abs_rs : abs_rt};
            end
            if (state == RUN) begin
                cnt <= cnt + CW'(1);
                if (!is_div)
                    acc <= {sum, acc[WIDTH-1:1]};
                else if (sum[WIDTH])
                    acc <= {acc[2*WIDTH-2:0], 1'b0};
                else
                    acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == FIX) begin
            if (is_div) begin
                lo_r <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                hi_r <= neg_r ? -acc[2*WIDTH-1:WIDTH]
                              : acc[2*WIDTH-1:WIDTH];
            end else begin
                {hi_r, lo_r} <= neg_q ? -acc : acc;
            end
        end else if (state == PREP && dz_cond) begin
            hi_r <= rs_r;
            lo_r <= '1;
        end
`ifdef MULDIV_HILO_WRITE_EN
        else if (!busy) begin
            if (bus.hi_wr) hi_r <= bus.wr_data;
            if (bus.lo_wr) lo_r <= bus.wr_data;
        end
`endif
    end

    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.div_by_zero = (state == DONE) & dz;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
`ifdef MULDIV_HILO_WRITE_EN
    assign bus.stall = busy & (bus.start | bus.hilo_read
                             | bus.hi_wr | bus.lo_wr);
`else
    assign bus.stall = busy & (bus.start | bus.hilo_read);
`endif
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: results, latency, stall, reset.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one op, then count edges until done; busy counted per cycle.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        int bcnt;
        bit seen;
        bus.start  = 1'b1;
        bus.op     = v.op;
        bus.rs_val = v.rs;
        bus.rt_val = v.rt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bcnt = int'(bus.busy);
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                n = i;
            end else begin
                bcnt += int'(bus.busy);
            end
        end
        check({tag, "_latency"}, 64'(n), 64'(v.lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(v.lat));
        check({tag, "_hi"}, 64'(bus.hi), 64'(v.hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(v.lo));
        check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(v.dz));
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, W + 2};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 1'b0, W + 2};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 2};
        vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000, 1'b0, W + 2};
        vecs[4] = '{2'b11, 32'd7, 32'd0,
                    32'd7, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5] = '{2'b01, 32'd3, 32'd4,
                    32'd0, 32'd12, 1'b0, W + 2};
        vecs[6] = '{2'b00, 32'h00010000, 32'h00010000,
                    32'd1, 32'd0, 1'b0, W + 2};
        vecs[7] = '{2'b10, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD, 1'b0, W + 2};
        vecs[8] = '{2'b11, 32'd100, 32'd7,
                    32'd2, 32'd14, 1'b0, W + 2};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.hilo_read = 1'b0;
`ifdef MULDIV_HILO_WRITE_EN
        bus.hi_wr   = 1'b0;
        bus.lo_wr   = 1'b0;
        bus.wr_data = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(bus.hi), 64'h0);
        check("rst_lo", 64'(bus.lo), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_dz", 64'(bus.div_by_zero), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Consecutive vectors start in the DONE cycle: back-to-back issue.
        for (int i = 0; i < 9; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of RUN aborts and clears HI/LO.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("midrun_busy", 64'(bus.busy), 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_done", 64'(bus.done), 64'h0);
        check("abort_hi", 64'(bus.hi), 64'h0);
        check("abort_lo", 64'(bus.lo), 64'h0);
        @(posedge clk);
        #1;
        check("abort_idle", 64'(bus.busy), 64'h0);
        v = '{2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, W + 2};
        run_op(v, "post_reset");

        // Start while busy is ignored and stalls; mfhi/mflo also stalls.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd4;
        @(posedge clk);
        #1;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd5;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_start%0d", i), 64'(bus.stall), 64'h1);
            @(posedge clk);
            #1;
        end
        bus.start     = 1'b0;
        bus.hilo_read = 1'b1;
        #1;
        check("stall_hiloread", 64'(bus.stall), 64'h1);
        bus.hilo_read = 1'b0;
        #1;
        check("stall_quiet", 64'(bus.stall), 64'h0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = bus.done;
            end
            check("held_done_seen", 64'(seen), 64'h1);
        end
        check("held_lo", 64'(bus.lo), 64'd12);
        check("held_hi", 64'(bus.hi), 64'd0);
        bus.hilo_read = 1'b1;
        #1;
        check("done_no_stall", 64'(bus.stall), 64'h0);
        bus.hilo_read = 1'b0;
        v = '{2'b01, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, W + 2};
        run_op(v, "b2b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
